// File: rtl/pkt_ingress_sequencer_if.sv
// Upstream packet stream into pkt_ingress_sequencer.
// The master drives words and framing; the slave (the sequencer) returns s_ready.
interface pkt_ingress_sequencer_if #(
    parameter int data_width = 64
);
    logic [data_width-1:0] s_data;
    logic                  s_valid;
    logic                  s_sop;
    logic                  s_eop;
    logic [2:0]            s_empty;
    logic                  s_ready;

    modport master (
        output s_data, s_valid, s_sop, s_eop, s_empty,
        input  s_ready
    );

    modport slave (
        input  s_data, s_valid, s_sop, s_eop, s_empty,
        output s_ready
    );
endinterface

// File: rtl/pkt_ingress_sequencer.sv
// Packet ingress sequencer: assigns each incoming packet to the next packet RAM
// slot in strict order, streams its words out with one cycle of latency,
// commits the byte length on eop and aborts on gaps, over-long packets or an
// unexpected sop. Slots stay busy from commit until downstream releases them.
//
// Optional feature: define ING_ABORT_CNT_EN to add a saturating abort counter
// on abort_cnt_out; without it the port is tied to zero.
module pkt_ingress_sequencer #(
    parameter int data_width = 64,
    parameter int ram_array  = 8,
    parameter int max_words  = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    pkt_ingress_sequencer_if.slave  up,
    input  logic                    release_in,
    input  logic [2:0]              release_seq_in,
    output logic [data_width-1:0]   data_out,
    output logic                    data_valid_out,
    output logic [2:0]              pack_seq_out,
    output logic [9:0]              data_length_out,
    output logic                    pack_done_out,
    output logic                    pack_err_out,
    output logic [ram_array-1:0]    slot_busy_out,
    output logic [15:0]             abort_cnt_out
);

    localparam int cnt_w = $clog2(max_words + 1);
    localparam logic [cnt_w-1:0] max_cnt = cnt_w'(max_words);

    typedef enum logic [1:0] {
        IDLE,
        PKT,
        DROP
    } state_t;

    state_t                 state_q;
    logic [2:0]             next_seq_q;
    logic [2:0]             pack_seq_q;
    logic [cnt_w-1:0]       word_cnt_q;
    logic [ram_array-1:0]   slot_busy_q;
    logic [data_width-1:0]  data_q;
    logic                   data_valid_q;
    logic [9:0]             length_q;
    logic                   pack_done_q;
    logic                   pack_err_q;

    logic                   slot_free;
    logic                   s_ready_w;
    logic                   accept;
    logic                   fwd;
    logic                   commit;
    logic                   abort;
    logic [9:0]             words_d;
    logic [9:0]             len_d;
    logic [ram_array-1:0]   busy_d;

    assign slot_free  = ~slot_busy_q[next_seq_q];
    assign accept     = up.s_valid & s_ready_w;
    assign up.s_ready = s_ready_w;

    // Decode this cycle's event: forward a word, commit, or abort the packet.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        s_ready_w = 1'b1;
        fwd       = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                // A busy next slot stalls the stream; it is never skipped.
                s_ready_w = slot_free;
                if (up.s_valid && slot_free && up.s_sop) begin
                    fwd    = 1'b1;
                    commit = up.s_eop;
                end
            end
            PKT: begin
                if (!up.s_valid || up.s_sop || (word_cnt_q >= max_cnt)) begin
                    abort = 1'b1;
                end else begin
                    fwd    = 1'b1;
                    commit = up.s_eop;
                end
            end
            DROP: begin
                // A fresh sop restarts a packet only if its slot is free.
                if (up.s_valid && up.s_sop && slot_free) begin
                    fwd    = 1'b1;
                    commit = up.s_eop;
                end
            end
            default: ;
        endcase
    end

    // Byte length of the committing packet, including the eop word, in 10 bits.
    always_comb begin
        words_d = 10'(word_cnt_q) + 10'd1;
        len_d   = (words_d << 3) - 10'(up.s_empty);
    end

    // Next busy bitmap: release and commit always target different slots.
    always_comb begin
        busy_d = slot_busy_q;
        if (release_in) begin
            busy_d[release_seq_in] = 1'b0;
        end
        if (commit) begin
            busy_d[next_seq_q] = 1'b1;
        end
    end

    // Sequencer FSM with registered write port, status pulses and slot state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            next_seq_q   <= 3'd0;
            pack_seq_q   <= 3'd0;
            word_cnt_q   <= '0;
            slot_busy_q  <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            length_q     <= 10'd0;
            pack_done_q  <= 1'b0;
            pack_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            data_valid_q <= fwd;
            pack_done_q  <= commit;
            pack_err_q   <= abort;
            slot_busy_q  <= busy_d;
            // One cycle behind next_seq so the eop word still carries its own slot.
            pack_seq_q   <= next_seq_q;
            if (fwd) begin
                data_q <= up.s_data;
            end
            if (commit) begin
                length_q   <= len_d;
                next_seq_q <= next_seq_q + 3'd1;
            end
            // The count is zero whenever no packet is open, so a start lands on 1.
            if (fwd && !commit) begin
                word_cnt_q <= word_cnt_q + cnt_w'(1);
            end else begin
                word_cnt_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (fwd && !commit) begin
                        state_q <= PKT;
                    end
                end
                PKT: begin
                    if (commit) begin
                        state_q <= IDLE;
                    end else if (abort) begin
                        // An offending eop word closes the packet already.
                        state_q <= (up.s_valid && up.s_eop) ? IDLE : DROP;
                    end
                end
                DROP: begin
                    if (accept) begin
                        if (fwd) begin
                            state_q <= commit ? IDLE : PKT;
                        end else if (up.s_sop || up.s_eop) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ING_ABORT_CNT_EN
    logic [15:0] abort_cnt_q;

    // Saturating count of aborted packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            abort_cnt_q <= 16'd0;
        end else if (abort && (abort_cnt_q != 16'hFFFF)) begin
            abort_cnt_q <= abort_cnt_q + 16'd1;
        end
    end

    assign abort_cnt_out = abort_cnt_q;
`else
    assign abort_cnt_out = 16'd0;
`endif

    assign data_out        = data_q;
    assign data_valid_out  = data_valid_q;
    assign pack_seq_out    = pack_seq_q;
    assign data_length_out = length_q;
    assign pack_done_out   = pack_done_q;
    assign pack_err_out    = pack_err_q;
    assign slot_busy_out   = slot_busy_q;

endmodule

// File: doc/pkt_ingress_sequencer.md
PKT_INGRESS_SEQUENCER -- requirements
Module: pkt_ingress_sequencer

Interface
REQ-001 SHALL have parameter data_width, default 64, meaning stream/output word width in bits.
REQ-002 SHALL have parameter ram_array, default 8, meaning number of packet slots; the 3-bit sequence width is fixed.
REQ-003 SHALL have parameter max_words, default 128, meaning maximum words per packet (1023 bytes / 8, rounded up).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_data  input  data_width  upstream packet word.
REQ-007 s_valid  input  1  upstream word valid.
REQ-008 s_sop  input  1  first word of packet, qualified by s_valid.
REQ-009 s_eop  input  1  last word of packet, qualified by s_valid.
REQ-010 s_empty  input  3  unused bytes in the eop word (0 = all 8 valid).
REQ-011 s_ready  output  1  block accepts a word this cycle.
REQ-012 release_in  input  1  one-cycle pulse, downstream has finished with a slot.
REQ-013 release_seq_in  input  3  slot number being released.
REQ-014 data_out  output  data_width  word to packet RAM array.
REQ-015 data_valid_out  output  1  write strobe; contiguous for a whole packet.
REQ-016 pack_seq_out  output  3  slot receiving the current packet.
REQ-017 data_length_out  output  10  committed packet length in bytes.
REQ-018 pack_done_out  output  1  one-cycle pulse, packet committed; qualifies data_length_out.
REQ-019 pack_err_out  output  1  one-cycle pulse, packet aborted.
REQ-020 slot_busy_out  output  ram_array  busy bitmap of committed, unreleased slots.

Function
REQ-021 SHALL implement states IDLE, PKT and DROP.
REQ-022 IDLE: s_ready = 1 iff slot_busy_out[next_seq] = 0; an accepted s_valid&s_sop word moves to PKT.
REQ-023 PKT: s_ready = 1; every accepted word is driven on data_out/data_valid_out one cycle later (latency 1).
REQ-024 Slots SHALL be allocated strictly in order 0..7, wrapping 7->0; a busy next slot stalls (s_ready=0) and is never skipped.
REQ-025 pack_seq_out SHALL equal next_seq and stay constant from sop until the cycle after the eop word is output.
REQ-026 The byte length SHALL be word_count*8 - s_empty, computed in 10 bits; data_length_out holds until the next commit.
REQ-027 On an accepted eop in PKT: pack_done_out pulses with the last data_valid_out cycle, slot_busy_out[next_seq] sets, next_seq increments, and the state returns to IDLE.
REQ-028 A single-word packet (sop and eop together) SHALL commit with length 8 - s_empty.
REQ-029 In PKT, s_valid=0 (gap) SHALL abort: pack_err_out pulses, slot is not marked busy, next_seq is unchanged, and the state moves to DROP.
REQ-030 In PKT, a word beyond max_words or s_sop without eop SHALL abort as in REQ-029; the offending word is discarded.
REQ-031 DROP: s_ready = 1; words are discarded until the accepted eop, then IDLE; a new s_sop in DROP is treated as a fresh packet start (PKT if the slot is free, else IDLE).
REQ-032 In IDLE, words without s_sop SHALL be discarded silently.
REQ-033 release_in SHALL clear slot_busy_out[release_seq_in] next cycle; releasing an already-free slot has no effect.
REQ-034 Release and commit on the same slot in the same cycle cannot occur (commit requires a free slot); release of slot X concurrent with commit of slot Y SHALL apply both.

Reset
REQ-035 reset SHALL force state IDLE, next_seq 0, slot_busy_out 0, data_out 0, data_valid_out 0, data_length_out 0, and pack_done_out/pack_err_out 0, with s_ready = 1 from the first cycle after reset.
REQ-036 reset mid-packet SHALL discard the packet without a pack_err_out pulse.

Configuration
REQ-037 Macro ING_ABORT_CNT_EN SHALL add output abort_cnt_out[15:0], which increments on every pack_err_out, saturates at 0xFFFF, and clears on reset.
REQ-038 Without ING_ABORT_CNT_EN, the port SHALL still exist, tied to 0, with no counter logic.

Verification
REQ-039 A 4-word packet, s_empty=3, into slot 0 -> 4 contiguous data_valid_out cycles, pack_seq_out=0, length 29, pack_done_out on the 4th, slot_busy_out=0x01.
REQ-040 8 back-to-back 1-word packets, no release -> slots 0..7 busy (0xFF), s_ready=0; then release_seq_in=0 -> s_ready=1 and the 9th packet is written to slot 0.
REQ-041 A gap after the 2nd word of a packet in slot 3 -> pack_err_out, slot 3 stays free, and the next packet uses slot 3.
REQ-042 A 129-word packet -> 128 words output, then pack_err_out; with ING_ABORT_CNT_EN, abort_cnt_out=1.
REQ-043 reset asserted on the 3rd word -> all outputs at reset values, no pack_err_out, and the next packet goes to slot 0.
